fetch_sequencer: RTL and testbench

//  Controller that drives the program counter's active-low reset/load/increment strobes and sequences instruction fetch.

---
 rtl/fetch_sequencer_pkg.sv | 20 ++
 rtl/fetch_sequencer_if.sv | 40 ++++
 rtl/fetch_sequencer_watchdog.sv | 41 ++++
 rtl/fetch_sequencer.sv | 164 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state
// encodings and the active level of the program-counter strobes.
package fetch_sequencer_pkg;

    // Sequencer states; 3-bit encoding leaves one spare code.
    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_VEC    = 3'd1,
        ST_FETCH  = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_UPDATE = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } state_e;

    // The PC's reset/load/increment inputs are all active low.
    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

endpackage : fetch_sequencer_pkg

// File: rtl/fetch_sequencer_if.sv
// Bundle of the sequencer's PC, instruction-memory and decoder signals.
// master = the sequencer; slave = the PC/memory/decoder side.
interface fetch_sequencer_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int INSTR_WIDTH = 16
);
    // Program counter control
    logic                   pc_rst_no;
    logic                   pc_ld_no;
    logic                   pc_inc_no;
    logic [DATA_WIDTH-1:0]  pc_target_o;
    // Instruction memory
    logic                   mem_rd_o;
    logic                   mem_ready_i;
    logic [INSTR_WIDTH-1:0] mem_rdata_i;
    // Decoder handshake and flow control
    logic [INSTR_WIDTH-1:0] ir_o;
    logic                   instr_valid_o;
    logic                   instr_ready_i;
    logic                   branch_i;
    logic [DATA_WIDTH-1:0]  branch_target_i;
    logic                   halt_i;
    logic                   resume_i;
    logic                   fault_o;

    modport master (
        output pc_rst_no, pc_ld_no, pc_inc_no, pc_target_o,
        output mem_rd_o, ir_o, instr_valid_o, fault_o,
        input  mem_ready_i, mem_rdata_i, instr_ready_i,
        input  branch_i, branch_target_i, halt_i, resume_i
    );

    modport slave (
        input  pc_rst_no, pc_ld_no, pc_inc_no, pc_target_o,
        input  mem_rd_o, ir_o, instr_valid_o, fault_o,
        output mem_ready_i, mem_rdata_i, instr_ready_i,
        output branch_i, branch_target_i, halt_i, resume_i
    );

endinterface : fetch_sequencer_if

// File: rtl/fetch_sequencer_watchdog.sv
// Fetch watchdog: counts consecutive FETCH cycles without memory data.
// expired_o flags the last permitted wait cycle so the FSM can fault on it.
module fetch_sequencer_watchdog #(
    parameter int WAIT_LIMIT = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    // Wide enough to hold WAIT_LIMIT itself, so the final increment on the
    // expiry edge cannot wrap before the FSM leaves FETCH.
    localparam int CW = $clog2(WAIT_LIMIT + 1);

    logic [CW-1:0] count_q, count_d;

    // Next count: clear has priority over enable.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == CW'(WAIT_LIMIT - 1));

endmodule : fetch_sequencer_watchdog

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the PC's active-low strobes, requests
// memory reads, captures the instruction and hands it to the decoder.
// All outputs are registered so PC strobes settle well before the PC's
// falling-edge sample.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    INSTR_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    WAIT_LIMIT   = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    fetch_sequencer_if.master bus
);
    state_e                 state_q, state_d;
    logic                   pc_rst_n_q, pc_rst_n_d;
    logic                   pc_ld_n_q, pc_ld_n_d;
    logic                   pc_inc_n_q, pc_inc_n_d;
    logic [DATA_WIDTH-1:0]  pc_target_q, pc_target_d;
    logic                   mem_rd_q, mem_rd_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic                   instr_valid_q, instr_valid_d;
    logic                   fault_q, fault_d;

    logic wd_enable;
    logic wd_clear;
    logic wd_expired;

    // Watchdog runs only while FETCH waits on memory; anything else restarts it.
    assign wd_enable = (state_q == ST_FETCH) && !bus.mem_ready_i;
    assign wd_clear  = !wd_enable;

    fetch_sequencer_watchdog #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_watchdog (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );

    // Next state plus the output values that take effect in that state.
    always_comb begin
        state_d       = state_q;
        pc_rst_n_d    = STROBE_OFF;
        pc_ld_n_d     = STROBE_OFF;
        pc_inc_n_d    = STROBE_OFF;
        pc_target_d   = pc_target_q;
        mem_rd_d      = 1'b0;
        ir_d          = ir_q;
        instr_valid_d = 1'b0;
        fault_d       = 1'b0;

        unique case (state_q)
            ST_RST: begin
                // Reset released: optionally load the vector before fetching.
                if (RESET_VECTOR != '0) begin
                    state_d   = ST_VEC;
                    pc_ld_n_d = STROBE_ON;
                end else begin
                    state_d  = ST_FETCH;
                    mem_rd_d = 1'b1;
                end
            end

            ST_VEC: begin
                state_d  = ST_FETCH;
                mem_rd_d = 1'b1;
            end

            ST_FETCH: begin
                // Data arriving on the last permitted cycle still wins.
                if (bus.mem_ready_i) begin
                    state_d       = ST_ISSUE;
                    ir_d          = bus.mem_rdata_i;
                    instr_valid_d = 1'b1;
                end else if (wd_expired) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else begin
                    mem_rd_d = 1'b1;
                end
            end

            ST_ISSUE: begin
                // branch_i/halt_i only matter on the accepting cycle.
                if (bus.instr_ready_i) begin
                    if (bus.halt_i) begin
                        state_d = ST_HALT;
                    end else if (bus.branch_i) begin
                        state_d     = ST_UPDATE;
                        pc_ld_n_d   = STROBE_ON;
                        pc_target_d = bus.branch_target_i;
                    end else begin
                        state_d    = ST_UPDATE;
                        pc_inc_n_d = STROBE_ON;
                    end
                end else begin
                    instr_valid_d = 1'b1;
                end
            end

            ST_UPDATE: begin
                state_d  = ST_FETCH;
                mem_rd_d = 1'b1;
            end

            ST_HALT: begin
                if (bus.resume_i) begin
                    state_d    = ST_UPDATE;
                    pc_inc_n_d = STROBE_ON;
                end
            end

            ST_FAULT: begin
                // Sticky until reset_i.
                fault_d = 1'b1;
            end

            default: begin
                state_d    = ST_RST;
                pc_rst_n_d = STROBE_ON;
            end
        endcase
    end

    // State and registered outputs; reset aborts any fetch in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_RST;
            pc_rst_n_q    <= STROBE_ON;
            pc_ld_n_q     <= STROBE_OFF;
            pc_inc_n_q    <= STROBE_OFF;
            pc_target_q   <= RESET_VECTOR;
            mem_rd_q      <= 1'b0;
            ir_q          <= '0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_rst_n_q    <= pc_rst_n_d;
            pc_ld_n_q     <= pc_ld_n_d;
            pc_inc_n_q    <= pc_inc_n_d;
            pc_target_q   <= pc_target_d;
            mem_rd_q      <= mem_rd_d;
            ir_q          <= ir_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
        end
    end

    assign bus.pc_rst_no     = pc_rst_n_q;
    assign bus.pc_ld_no      = pc_ld_n_q;
    assign bus.pc_inc_no     = pc_inc_n_q;
    assign bus.pc_target_o   = pc_target_q;
    assign bus.mem_rd_o      = mem_rd_q;
    assign bus.ir_o          = ir_q;
    assign bus.instr_valid_o = instr_valid_q;
    assign bus.fault_o       = fault_q;

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios followed by randomized
// transactions. A behavioural PC reacts to the strobes on the falling edge;
// expected PC values come from transaction arithmetic (next = pc+1 or target).
module tb_fetch_sequencer;
    localparam int             DW = 16;
    localparam int             IW = 16;
    localparam logic [DW-1:0]  RV = 16'h0100;
    localparam int             WL = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.DATA_WIDTH(DW), .INSTR_WIDTH(IW)) bus_if ();

    fetch_sequencer #(
        .DATA_WIDTH   (DW),
        .INSTR_WIDTH  (IW),
        .RESET_VECTOR (RV),
        .WAIT_LIMIT   (WL)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Behavioural program counter plus strobe-pulse bookkeeping.
    logic [DW-1:0] pc_model = '0;
    int ld_cnt    = 0;
    int inc_cnt   = 0;
    int both_low  = 0;

    always @(negedge clk) begin
        if (bus_if.pc_ld_no === 1'b0)  ld_cnt++;
        if (bus_if.pc_inc_no === 1'b0) inc_cnt++;
        if (bus_if.pc_ld_no === 1'b0 && bus_if.pc_inc_no === 1'b0) both_low++;
        if (bus_if.pc_rst_no === 1'b0)      pc_model <= '0;
        else if (bus_if.pc_ld_no === 1'b0)  pc_model <= bus_if.pc_target_o;
        else if (bus_if.pc_inc_no === 1'b0) pc_model <= pc_model + 16'd1;
    end

    int            ld_base, inc_base;
    int unsigned   r_wait, r_stall, r_hold;
    logic          r_halt, r_branch;
    logic [IW-1:0] r_data;
    logic [DW-1:0] r_tgt, exp_pc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_if.mem_ready_i     = 1'b0;
        bus_if.mem_rdata_i     = '0;
        bus_if.instr_ready_i   = 1'b0;
        bus_if.branch_i        = 1'b0;
        bus_if.branch_target_i = '0;
        bus_if.halt_i          = 1'b0;
        bus_if.resume_i        = 1'b0;
    endtask

    task automatic snap();
        ld_base  = ld_cnt;
        inc_base = inc_cnt;
    endtask

    task automatic check_pulses(input string tag, input int exp_ld, input int exp_inc);
        check({tag, "_ld_pulses"},  32'(ld_cnt - ld_base),   32'(exp_ld));
        check({tag, "_inc_pulses"}, 32'(inc_cnt - inc_base), 32'(exp_inc));
    endtask

    initial begin : main
        reset = 1'b1;
        idle_inputs();

        // ---- Reset state, vector load, first fetch request ----
        tick();
        tick();
        check("rst_pc_rst_no",   32'(bus_if.pc_rst_no), 32'(0));
        check("rst_pc_ld_no",    32'(bus_if.pc_ld_no), 32'(1));
        check("rst_pc_inc_no",   32'(bus_if.pc_inc_no), 32'(1));
        check("rst_pc_target",   32'(bus_if.pc_target_o), 32'(RV));
        check("rst_mem_rd",      32'(bus_if.mem_rd_o), 32'(0));
        check("rst_ir",          32'(bus_if.ir_o), 32'(0));
        check("rst_valid",       32'(bus_if.instr_valid_o), 32'(0));
        check("rst_fault",       32'(bus_if.fault_o), 32'(0));
        reset = 1'b0;
        snap();
        tick();
        check("vec_pc_rst_no",   32'(bus_if.pc_rst_no), 32'(1));
        check("vec_pc_ld_no",    32'(bus_if.pc_ld_no), 32'(0));
        check("vec_target",      32'(bus_if.pc_target_o), 32'(RV));
        check("vec_mem_rd",      32'(bus_if.mem_rd_o), 32'(0));
        tick();
        check("vec_end_ld_no",   32'(bus_if.pc_ld_no), 32'(1));
        check("first_mem_rd",    32'(bus_if.mem_rd_o), 32'(1));
        check("vec_pc",          32'(pc_model), 32'(RV));
        check_pulses("vec", 1, 0);

        // ---- Fetch with 3 wait cycles, then sequential advance ----
        repeat (3) tick();
        check("wait_mem_rd",     32'(bus_if.mem_rd_o), 32'(1));
        check("wait_valid",      32'(bus_if.instr_valid_o), 32'(0));
        bus_if.mem_ready_i = 1'b1;
        bus_if.mem_rdata_i = 16'hA55A;
        tick();
        bus_if.mem_ready_i = 1'b0;
        bus_if.mem_rdata_i = 16'hFFFF;
        check("cap_valid",       32'(bus_if.instr_valid_o), 32'(1));
        check("cap_ir",          32'(bus_if.ir_o), 32'(16'hA55A));
        check("cap_mem_rd",      32'(bus_if.mem_rd_o), 32'(0));
        bus_if.instr_ready_i = 1'b1;
        snap();
        tick();
        bus_if.instr_ready_i = 1'b0;
        check("inc_valid",       32'(bus_if.instr_valid_o), 32'(0));
        check("inc_pc_inc_no",   32'(bus_if.pc_inc_no), 32'(0));
        check("inc_mem_rd",      32'(bus_if.mem_rd_o), 32'(0));
        tick();
        check("inc_next_mem_rd", 32'(bus_if.mem_rd_o), 32'(1));
        check("inc_pc",          32'(pc_model), 32'(RV + 16'd1));
        check_pulses("inc", 0, 1);

        // ---- Decoder stall: output held, flow inputs ignored ----
        bus_if.mem_ready_i = 1'b1;
        bus_if.mem_rdata_i = 16'h1234;
        tick();
        bus_if.mem_ready_i = 1'b0;
        snap();
        for (int i = 0; i < 5; i++) begin
            bus_if.branch_i = 1'b1;
            bus_if.halt_i   = 1'b1;
            tick();
            check("stall_valid", 32'(bus_if.instr_valid_o), 32'(1));
            check("stall_ir",    32'(bus_if.ir_o), 32'(16'h1234));
        end
        check_pulses("stall", 0, 0);

        // ---- Branch on accept ----
        bus_if.halt_i          = 1'b0;
        bus_if.branch_i        = 1'b1;
        bus_if.branch_target_i = 16'h0040;
        bus_if.instr_ready_i   = 1'b1;
        tick();
        idle_inputs();
        check("br_pc_ld_no",     32'(bus_if.pc_ld_no), 32'(0));
        check("br_target",       32'(bus_if.pc_target_o), 32'(16'h0040));
        tick();
        check("br_mem_rd",       32'(bus_if.mem_rd_o), 32'(1));
        check("br_pc",           32'(pc_model), 32'(16'h0040));
        check_pulses("br", 1, 0);

        // ---- Halt beats branch; resume increments ----
        bus_if.mem_ready_i = 1'b1;
        bus_if.mem_rdata_i = 16'hBEEF;
        tick();
        idle_inputs();
        bus_if.instr_ready_i   = 1'b1;
        bus_if.halt_i          = 1'b1;
        bus_if.branch_i        = 1'b1;
        bus_if.branch_target_i = 16'h1111;
        snap();
        tick();
        idle_inputs();
        check("halt_valid",      32'(bus_if.instr_valid_o), 32'(0));
        repeat (3) tick();
        check("halt_mem_rd",     32'(bus_if.mem_rd_o), 32'(0));
        check("halt_target",     32'(bus_if.pc_target_o), 32'(16'h0040));
        check("halt_pc",         32'(pc_model), 32'(16'h0040));
        check_pulses("halt", 0, 0);
        bus_if.resume_i = 1'b1;
        tick();
        bus_if.resume_i = 1'b0;
        check("resume_inc_no",   32'(bus_if.pc_inc_no), 32'(0));
        tick();
        check("resume_mem_rd",   32'(bus_if.mem_rd_o), 32'(1));
        check("resume_pc",       32'(pc_model), 32'(16'h0041));
        check_pulses("resume", 0, 1);

        // ---- Reset in the middle of a fetch ----
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_mem_rd",   32'(bus_if.mem_rd_o), 32'(0));
        check("midrst_rst_no",   32'(bus_if.pc_rst_no), 32'(0));
        tick();
        tick();
        check("midrst_refetch",  32'(bus_if.mem_rd_o), 32'(1));
        check("midrst_pc",       32'(pc_model), 32'(RV));

        // ---- Ready on the last permitted wait cycle: no fault ----
        repeat (WL - 1) tick();
        check("lim_mem_rd",      32'(bus_if.mem_rd_o), 32'(1));
        bus_if.mem_ready_i = 1'b1;
        bus_if.mem_rdata_i = 16'hC3C3;
        tick();
        bus_if.mem_ready_i = 1'b0;
        check("lim_valid",       32'(bus_if.instr_valid_o), 32'(1));
        check("lim_fault",       32'(bus_if.fault_o), 32'(0));
        check("lim_ir",          32'(bus_if.ir_o), 32'(16'hC3C3));
        bus_if.instr_ready_i = 1'b1;
        tick();
        bus_if.instr_ready_i = 1'b0;
        tick();
        check("lim_next_mem_rd", 32'(bus_if.mem_rd_o), 32'(1));
        check("lim_pc",          32'(pc_model), 32'(RV + 16'd1));

        // ---- Watchdog timeout: sticky fault until reset ----
        repeat (WL - 1) tick();
        check("to_pre_fault",    32'(bus_if.fault_o), 32'(0));
        check("to_pre_mem_rd",   32'(bus_if.mem_rd_o), 32'(1));
        tick();
        check("to_fault",        32'(bus_if.fault_o), 32'(1));
        check("to_mem_rd",       32'(bus_if.mem_rd_o), 32'(0));
        bus_if.mem_ready_i   = 1'b1;
        bus_if.instr_ready_i = 1'b1;
        bus_if.resume_i      = 1'b1;
        snap();
        repeat (4) tick();
        idle_inputs();
        check("to_sticky",       32'(bus_if.fault_o), 32'(1));
        check("to_valid",        32'(bus_if.instr_valid_o), 32'(0));
        check("to_mem_rd_hold",  32'(bus_if.mem_rd_o), 32'(0));
        check_pulses("to", 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("to_cleared",      32'(bus_if.fault_o), 32'(0));
        tick();
        tick();
        exp_pc = RV;

        // ---- Randomized transactions against the transaction model ----
        for (int t = 0; t < 24; t++) begin
            r_wait   = $urandom_range(WL - 1, 0);
            r_stall  = $urandom_range(3, 0);
            r_hold   = $urandom_range(3, 0);
            r_data   = IW'($urandom);
            r_tgt    = DW'($urandom);
            r_halt   = ($urandom_range(3, 0) == 0);
            r_branch = 1'($urandom_range(1, 0));

            check("rnd_fetch_rd", 32'(bus_if.mem_rd_o), 32'(1));
            check("rnd_fetch_pc", 32'(pc_model), 32'(exp_pc));
            repeat (r_wait) begin
                bus_if.mem_rdata_i = IW'($urandom);
                tick();
            end
            bus_if.mem_ready_i = 1'b1;
            bus_if.mem_rdata_i = r_data;
            tick();
            bus_if.mem_ready_i = 1'b0;
            repeat (r_stall) begin
                bus_if.branch_i = 1'($urandom_range(1, 0));
                bus_if.halt_i   = 1'($urandom_range(1, 0));
                tick();
            end
            check("rnd_valid", 32'(bus_if.instr_valid_o), 32'(1));
            check("rnd_ir",    32'(bus_if.ir_o), 32'(r_data));

            bus_if.instr_ready_i   = 1'b1;
            bus_if.halt_i          = r_halt;
            bus_if.branch_i        = r_branch;
            bus_if.branch_target_i = r_tgt;
            snap();
            tick();
            idle_inputs();
            check("rnd_accept_valid", 32'(bus_if.instr_valid_o), 32'(0));
            if (r_halt) begin
                repeat (r_hold) tick();
                check("rnd_halt_mem_rd", 32'(bus_if.mem_rd_o), 32'(0));
                bus_if.resume_i = 1'b1;
                tick();
                bus_if.resume_i = 1'b0;
                exp_pc = exp_pc + 16'd1;
            end else if (r_branch) begin
                exp_pc = r_tgt;
            end else begin
                exp_pc = exp_pc + 16'd1;
            end
            tick();
            check_pulses("rnd", (!r_halt && r_branch) ? 1 : 0, (r_halt || !r_branch) ? 1 : 0);
        end
        check("rnd_final_pc", 32'(pc_model), 32'(exp_pc));

        check("ld_inc_exclusive", 32'(both_low), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fetch_sequencer
